// File: rtl/hd44780_responder.sv
// ---------------------------------------------------------------------------
// hd44780_responder
//   Receiving end of an HD44780-style RS/RW/E/DB bus. Decodes instructions,
//   holds the 80-byte DDRAM, the address counter and the display/entry/shift
//   state, models busy timing, and answers busy-flag and data reads. It is
//   used as a loopback target and as a debug mirror of the panel contents.
//
// Ports
//   clock        system clock (at least 8x the E strobe rate)
//   reset        synchronous, active-low reset
//   RS, RW, E    bus control (E is asynchronous to clock)
//   DB_in        bus data from the initiator
//   DB_out       read data, DB_oe high while it is driven
//   rd_addr      debug DDRAM read address (linear 0..79)
//   rd_data      DDRAM[rd_addr], one cycle latency
//   ac           address counter (HD44780 DDRAM address)
//   shift_offset display shift, 0..39
//   display_on, cursor_on, blink_on  display-control D/C/B bits
//   incr, entry_shift                entry-mode I/D and S bits
//   line2                            function-set N bit
//   busy         busy flag
//   cmd_strobe   one-cycle pulse per accepted write
//   err          one-cycle pulse on a rejected or unsupported operation
// ---------------------------------------------------------------------------
module hd44780_responder #(
  parameter int BUSY_CYCLES    = 37,
  parameter int HOME_CYCLES    = 1520,
  parameter int CLEAR_CYCLES   = 1520,
  parameter int POWERUP_CYCLES = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RS,
  input  logic       RW,
  input  logic       E,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic [5:0] shift_offset,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic       entry_shift,
  output logic       line2,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       err
);

  localparam logic [6:0] DDRAM_DEPTH = 7'd80;
  localparam logic [6:0] FILL_LAST   = 7'd79;

  // Address helpers ---------------------------------------------------------

  // HD44780 address to linear DDRAM index (second line starts at index 40).
  function automatic logic [6:0] lin_addr(input logic [6:0] a, input logic two_line);
    if (two_line && (a >= 7'h40)) begin
      lin_addr = a - 7'd24;
    end else begin
      lin_addr = a;
    end
  endfunction

  function automatic logic addr_legal(input logic [6:0] a, input logic two_line);
    if (two_line) begin
      addr_legal = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    end else begin
      addr_legal = (a <= 7'h4F);
    end
  endfunction

  // One address-counter step, jumping the gaps between lines.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                         input logic two_line);
    if (two_line) begin
      if (up) begin
        if (a == 7'h27)      ac_step = 7'h40;
        else if (a == 7'h67) ac_step = 7'h00;
        else                 ac_step = a + 7'd1;
      end else begin
        if (a == 7'h40)      ac_step = 7'h27;
        else if (a == 7'h00) ac_step = 7'h67;
        else                 ac_step = a - 7'd1;
      end
    end else begin
      if (up) begin
        ac_step = (a == 7'h4F) ? 7'h00 : (a + 7'd1);
      end else begin
        ac_step = (a == 7'h00) ? 7'h4F : (a - 7'd1);
      end
    end
  endfunction

  // Display shift step modulo 40.
  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
    if (up) begin
      shift_step = (s == 6'd39) ? 6'd0 : (s + 6'd1);
    end else begin
      shift_step = (s == 6'd0) ? 6'd39 : (s - 6'd1);
    end
  endfunction

  // State -------------------------------------------------------------------

  logic [10:0] sync1_r, sync2_r;   // {E, RS, RW, DB}
  logic        e_prev_r;
  logic [15:0] busy_cnt_r;
  logic        busy_r;
  logic        fill_active_r;
  logic [6:0]  fill_idx_r;
  logic [6:0]  ac_r;
  logic [5:0]  shift_r;
  logic        display_on_r, cursor_on_r, blink_on_r;
  logic        incr_r, entry_shift_r, line2_r;
  logic        cmd_strobe_r, err_r;
  logic [7:0]  db_out_r;
  logic        db_oe_r;
  logic [7:0]  rd_data_r;
  logic [7:0]  ddram_r [0:79];

  logic        e_s, rs_s, rw_s;
  logic [7:0]  db_s;
  logic        wr_fall_s, rd_fall_s;
  logic [6:0]  cur_lin_s;
  logic        ddram_we_s;
  logic [6:0]  ddram_waddr_s;
  logic [7:0]  ddram_wdata_s;

  // Synchronized bus view, fall detection and DDRAM write-port selection.
  always_comb begin
    e_s           = sync2_r[10];
    rs_s          = sync2_r[9];
    rw_s          = sync2_r[8];
    db_s          = sync2_r[7:0];
    wr_fall_s     = e_prev_r && !e_s && !rw_s;
    rd_fall_s     = e_prev_r && !e_s && rw_s && rs_s;
    cur_lin_s     = lin_addr(ac_r, line2_r);
    ddram_we_s    = 1'b0;
    ddram_waddr_s = 7'd0;
    ddram_wdata_s = 8'h00;
    if (!reset) begin
      ddram_we_s = 1'b0;
    end else if (fill_active_r) begin
      // Clear fill owns the port; busy is high so no data write can collide.
      ddram_we_s    = 1'b1;
      ddram_waddr_s = fill_idx_r;
      ddram_wdata_s = 8'h20;
    end else if (wr_fall_s && rs_s && !busy_r && (cur_lin_s < DDRAM_DEPTH)) begin
      ddram_we_s    = 1'b1;
      ddram_waddr_s = cur_lin_s;
      ddram_wdata_s = db_s;
    end else begin
      ddram_we_s = 1'b0;
    end
  end

  // DDRAM storage: not reset, so bytes already cleared survive a reset.
  always_ff @(posedge clock) begin
    if (ddram_we_s) begin
      ddram_r[ddram_waddr_s] <= ddram_wdata_s;
    end
  end

  // Bus synchronizer, edge history, and registered read ports.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_r   <= 11'd0;
      sync2_r   <= 11'd0;
      e_prev_r  <= 1'b0;
      db_out_r  <= 8'h00;
      db_oe_r   <= 1'b0;
      rd_data_r <= 8'h00;
    end else begin
      sync1_r  <= {E, RS, RW, DB_in};
      sync2_r  <= sync1_r;
      e_prev_r <= e_s;
      if (e_s && rw_s) begin
        db_oe_r <= 1'b1;
        if (rs_s) begin
          db_out_r <= (cur_lin_s < DDRAM_DEPTH) ? ddram_r[cur_lin_s] : 8'h00;
        end else begin
          db_out_r <= {busy_r, ac_r};
        end
      end else begin
        db_oe_r  <= 1'b0;
        db_out_r <= 8'h00;
      end
      // Old byte is returned when rd_addr collides with a write this cycle.
      rd_data_r <= (rd_addr < DDRAM_DEPTH) ? ddram_r[rd_addr] : 8'h00;
    end
  end

  // Busy timing, clear fill sequencing and instruction/data execution.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_cnt_r    <= 16'(POWERUP_CYCLES);
      busy_r        <= 1'b1;
      fill_active_r <= 1'b0;
      fill_idx_r    <= 7'd0;
      ac_r          <= 7'd0;
      shift_r       <= 6'd0;
      display_on_r  <= 1'b0;
      cursor_on_r   <= 1'b0;
      blink_on_r    <= 1'b0;
      incr_r        <= 1'b1;
      entry_shift_r <= 1'b0;
      line2_r       <= 1'b1;
      cmd_strobe_r  <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      // Flag lags the counter by one cycle, so a fall on the cycle the
      // counter reaches zero is still rejected.
      if (busy_cnt_r != 16'd0) begin
        busy_cnt_r <= busy_cnt_r - 16'd1;
      end
      busy_r <= (busy_cnt_r != 16'd0);

      if (fill_active_r) begin
        fill_idx_r    <= fill_idx_r + 7'd1;
        fill_active_r <= (fill_idx_r != FILL_LAST);
      end

      cmd_strobe_r <= 1'b0;
      err_r        <= 1'b0;

      if (wr_fall_s) begin
        if (busy_r) begin
          err_r <= 1'b1;
        end else begin
          cmd_strobe_r <= 1'b1;
          busy_r       <= 1'b1;
          busy_cnt_r   <= 16'(BUSY_CYCLES);
          if (rs_s) begin
            ac_r <= ac_step(ac_r, incr_r, line2_r);
            if (entry_shift_r) begin
              shift_r <= shift_step(shift_r, incr_r);
            end
          end else begin
            // Decode by the highest set bit of the instruction byte.
            casez (db_s)
              8'b1???_????: begin
                if (addr_legal(db_s[6:0], line2_r)) begin
                  ac_r <= db_s[6:0];
                end else begin
                  err_r <= 1'b1;
                end
              end
              8'b01??_????: begin
                err_r <= 1'b1;
              end
              8'b001?_????: begin
                if (!db_s[4]) begin
                  err_r <= 1'b1;
                end else begin
                  line2_r <= db_s[3];
                end
              end
              8'b0001_????: begin
                if (db_s[3]) begin
                  shift_r <= shift_step(shift_r, db_s[2]);
                end else begin
                  ac_r <= ac_step(ac_r, db_s[2], line2_r);
                end
              end
              8'b0000_1???: begin
                display_on_r <= db_s[2];
                cursor_on_r  <= db_s[1];
                blink_on_r   <= db_s[0];
              end
              8'b0000_01??: begin
                incr_r        <= db_s[1];
                entry_shift_r <= db_s[0];
              end
              8'b0000_001?: begin
                ac_r       <= 7'd0;
                shift_r    <= 6'd0;
                busy_cnt_r <= 16'(HOME_CYCLES);
              end
              8'b0000_0001: begin
                ac_r          <= 7'd0;
                shift_r       <= 6'd0;
                incr_r        <= 1'b1;
                fill_active_r <= 1'b1;
                fill_idx_r    <= 7'd0;
                busy_cnt_r    <= 16'(CLEAR_CYCLES);
              end
              default: begin
                err_r <= 1'b0;
              end
            endcase
          end
        end
      end else if (rd_fall_s) begin
        if (busy_r) begin
          err_r <= 1'b1;
        end else begin
          ac_r <= ac_step(ac_r, incr_r, line2_r);
          if (entry_shift_r) begin
            shift_r <= shift_step(shift_r, incr_r);
          end
        end
      end
    end
  end

  assign DB_out       = db_out_r;
  assign DB_oe        = db_oe_r;
  assign rd_data      = rd_data_r;
  assign ac           = ac_r;
  assign shift_offset = shift_r;
  assign display_on   = display_on_r;
  assign cursor_on    = cursor_on_r;
  assign blink_on     = blink_on_r;
  assign incr         = incr_r;
  assign entry_shift  = entry_shift_r;
  assign line2        = line2_r;
  assign busy         = busy_r;
  assign cmd_strobe   = cmd_strobe_r;
  assign err          = err_r;

endmodule

// File: tb/tb_hd44780_responder.sv
// ---------------------------------------------------------------------------
// tb_hd44780_responder
//   Directed bench for hd44780_responder: a table of bus writes with the
//   expected address counter and error behaviour, followed by hand-written
//   sequences for busy-window rejection, data read and mid-clear reset.
// ---------------------------------------------------------------------------
module tb_hd44780_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RS = 1'b0;
  logic       RW = 1'b0;
  logic       E = 1'b0;
  logic [7:0] DB_in = 8'h00;
  logic [6:0] rd_addr = 7'd0;
  logic [7:0] DB_out;
  logic       DB_oe;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic [5:0] shift_offset;
  logic       display_on, cursor_on, blink_on, incr, entry_shift, line2;
  logic       busy, cmd_strobe, err;

  hd44780_responder dut (
    .clock(clock), .reset(reset), .RS(RS), .RW(RW), .E(E), .DB_in(DB_in),
    .DB_out(DB_out), .DB_oe(DB_oe), .rd_addr(rd_addr), .rd_data(rd_data),
    .ac(ac), .shift_offset(shift_offset), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .incr(incr),
    .entry_shift(entry_shift), .line2(line2), .busy(busy),
    .cmd_strobe(cmd_strobe), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int s0, e0;
  logic got;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    logic [6:0] exp_ac;
    int         exp_err;
  } vec_t;

  vec_t       vecs [0:28];
  logic [7:0] exp_mem [0:79];

  // Pulse counters sampled away from the active edge.
  always @(negedge clock) begin
    if (cmd_strobe) strobe_cnt = strobe_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] db);
    @(negedge clock);
    RS = rs; RW = 1'b0; DB_in = db;
    repeat (2) @(negedge clock);
    E = 1'b1;
    repeat (6) @(negedge clock);
    E = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic wait_not_busy(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("busy_release", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_mem(input int idx, input logic [7:0] exp);
    @(negedge clock);
    rd_addr = 7'(idx);
    @(negedge clock);
    check($sformatf("ddram[%0d]", idx), {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h38, 7'h00, 0};
    vecs[1]  = '{1'b0, 8'h38, 7'h00, 0};
    vecs[2]  = '{1'b0, 8'h38, 7'h00, 0};
    vecs[3]  = '{1'b0, 8'h38, 7'h00, 0};
    vecs[4]  = '{1'b0, 8'h01, 7'h00, 0};
    vecs[5]  = '{1'b0, 8'h0C, 7'h00, 0};
    vecs[6]  = '{1'b0, 8'h06, 7'h00, 0};
    vecs[7]  = '{1'b1, 8'h52, 7'h01, 0};  // R
    vecs[8]  = '{1'b1, 8'h45, 7'h02, 0};  // E
    vecs[9]  = '{1'b1, 8'h44, 7'h03, 0};  // D
    vecs[10] = '{1'b1, 8'h58, 7'h04, 0};  // X
    vecs[11] = '{1'b1, 8'h59, 7'h05, 0};  // Y
    vecs[12] = '{1'b1, 8'h73, 7'h06, 0};  // s
    vecs[13] = '{1'b0, 8'hC0, 7'h40, 0};
    vecs[14] = '{1'b1, 8'h47, 7'h41, 0};  // G
    vecs[15] = '{1'b1, 8'h52, 7'h42, 0};  // R
    vecs[16] = '{1'b1, 8'h4E, 7'h43, 0};  // N
    vecs[17] = '{1'b0, 8'hA8, 7'h43, 1};  // illegal address 0x28
    vecs[18] = '{1'b0, 8'h28, 7'h43, 1};  // 4-bit mode
    vecs[19] = '{1'b0, 8'hA7, 7'h27, 0};
    vecs[20] = '{1'b1, 8'h61, 7'h40, 0};  // 0x27 -> 0x40
    vecs[21] = '{1'b0, 8'hE7, 7'h67, 0};
    vecs[22] = '{1'b1, 8'hFF, 7'h00, 0};  // 0x67 -> 0x00
    vecs[23] = '{1'b0, 8'h04, 7'h00, 0};  // decrement
    vecs[24] = '{1'b1, 8'h52, 7'h67, 0};  // 0x00 -> 0x67
    vecs[25] = '{1'b0, 8'h06, 7'h67, 0};
    vecs[26] = '{1'b0, 8'h14, 7'h00, 0};  // cursor right wraps 0x67 -> 0x00
    vecs[27] = '{1'b0, 8'h1C, 7'h00, 0};  // display shift right
    vecs[28] = '{1'b0, 8'h80, 7'h00, 0};

    for (int i = 0; i < 80; i++) exp_mem[i] = 8'h20;
    exp_mem[0] = 8'h52; exp_mem[1] = 8'h45; exp_mem[2] = 8'h44;
    exp_mem[3] = 8'h58; exp_mem[4] = 8'h59; exp_mem[5] = 8'h73;
    exp_mem[39] = 8'h61;
    exp_mem[40] = 8'h47; exp_mem[41] = 8'h52; exp_mem[42] = 8'h4E;
    exp_mem[79] = 8'hFF;

    // Reset values.
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ac", {25'd0, ac}, 32'd0);
    check("rst_incr_line2", {30'd0, incr, line2}, 32'd3);
    check("rst_ctrl", {26'd0, display_on, cursor_on, blink_on, entry_shift, DB_oe, err}, 32'd0);
    check("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
    check("rst_db_out", {24'd0, DB_out}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    reset = 1'b1;
    wait_not_busy(300);

    // Table of writes with expected address counter and error pulses.
    for (int i = 0; i < 29; i++) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      bus_write(vecs[i].rs, vecs[i].db);
      check($sformatf("vec%0d_ac", i), {25'd0, ac}, {25'd0, vecs[i].exp_ac});
      check($sformatf("vec%0d_strobe", i), strobe_cnt - s0, 32'd1);
      check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      wait_not_busy(3000);
    end

    check("line2", {31'd0, line2}, 32'd1);
    check("dcb", {29'd0, display_on, cursor_on, blink_on}, 32'd4);
    check("entry", {30'd0, incr, entry_shift}, 32'd2);
    check("shift_offset", {26'd0, shift_offset}, 32'd1);
    for (int i = 0; i < 80; i++) read_mem(i, exp_mem[i]);

    // Data read at ac=0 returns 'R' and advances ac.
    @(negedge clock);
    RS = 1'b1; RW = 1'b1;
    repeat (2) @(negedge clock);
    E = 1'b1;
    repeat (4) @(negedge clock);
    check("dread_oe", {31'd0, DB_oe}, 32'd1);
    check("dread_data", {24'd0, DB_out}, 32'h52);
    E = 1'b0;
    repeat (6) @(negedge clock);
    check("dread_ac", {25'd0, ac}, 32'd1);
    check("dread_oe_off", {31'd0, DB_oe}, 32'd0);

    // Busy window: busy-flag read, then a rejected write.
    bus_write(1'b0, 8'h80);
    check("bw_busy", {31'd0, busy}, 32'd1);
    RS = 1'b0; RW = 1'b1;
    @(negedge clock);
    E = 1'b1;
    repeat (4) @(negedge clock);
    check("bflag_read", {24'd0, DB_out}, 32'h80);
    check("bflag_oe", {31'd0, DB_oe}, 32'd1);
    E = 1'b0;
    repeat (3) @(negedge clock);
    s0 = strobe_cnt;
    e0 = err_cnt;
    bus_write(1'b1, 8'h5A);
    check("busy_wr_err", err_cnt - e0, 32'd1);
    check("busy_wr_strobe", strobe_cnt - s0, 32'd0);
    check("busy_wr_ac", {25'd0, ac}, 32'd0);
    wait_not_busy(300);
    read_mem(0, 8'h52);

    // Reset ten cycles into a clear fill.
    @(negedge clock);
    RS = 1'b0; RW = 1'b0; DB_in = 8'h01;
    repeat (2) @(negedge clock);
    E = 1'b1;
    repeat (6) @(negedge clock);
    E = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (cmd_strobe) begin
        got = 1'b1;
        break;
      end
    end
    check("clr_strobe", {31'd0, got}, 32'd1);
    repeat (10) @(negedge clock);
    check("pre_rst_disp", {31'd0, display_on}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_ac", {25'd0, ac}, 32'd0);
    check("mid_rst_disp", {31'd0, display_on}, 32'd0);
    check("mid_rst_line2", {31'd0, line2}, 32'd1);
    reset = 1'b1;
    repeat (95) @(negedge clock);
    check("powerup_busy", {31'd0, busy}, 32'd1);
    wait_not_busy(40);
    read_mem(0, 8'h20);
    read_mem(5, 8'h20);
    read_mem(41, 8'h52);
    read_mem(79, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
